// File: rtl/countdown_timer_ctrl.sv
// Front-panel sequencer for the countdown timer: edits the BCD HH:MM:SS preset,
// loads it, gates the 1 Hz decrement through pause, and runs the auto-silencing alarm.
module countdown_timer_ctrl #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int RING_SECS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       timer_ring,
  output logic [7:0] hour_set,
  output logic [7:0] minute_set,
  output logic [7:0] second_set,
  output logic       set_timer,
  output logic       reset_timer,
  output logic       pause,
  output logic [1:0] edit_field,
  output logic       alarm_out,
  output logic       running
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (RING_SECS > 1) ? $clog2(RING_SECS + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SEC_LAST = SW'(RING_SECS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT_H,
    S_EDIT_M,
    S_EDIT_S,
    S_RUN,
    S_HOLD,
    S_ALARM
  } state_t;

  // state is left as a plain named register so checkers can bind to it
  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [SW-1:0] secs;
  logic [SW-1:0] secs_nxt;
  logic          loaded;
  logic          set_nxt;
  logic          rtm_nxt;
  logic [1:0]    field_nxt;
  logic          tick;
  logic          preset_zero;
  logic          do_clear;
  logic          do_start;
  logic          do_mode;
  logic          do_up;
  logic          any_btn;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == max_v) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Only the highest-priority pulse of a simultaneous group is acted on.
  assign do_clear = btn_clear;
  assign do_start = btn_start & ~btn_clear;
  assign do_mode  = btn_mode & ~btn_start & ~btn_clear;
  assign do_up    = btn_up & ~btn_mode & ~btn_start & ~btn_clear;
  assign any_btn  = btn_clear | btn_start | btn_mode | btn_up;

  assign preset_zero = (hour_set == 8'h00) && (minute_set == 8'h00) && (second_set == 8'h00);
  assign tick = ((state == S_RUN) || (state == S_ALARM)) && (cnt == CNT_MAX);

  always_comb begin
    state_nxt = state;
    set_nxt   = 1'b0;
    rtm_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (do_mode) begin
          state_nxt = S_EDIT_H;
        end else if (do_start && loaded && !preset_zero) begin
          state_nxt = S_RUN;
        end
      end
      S_EDIT_H: if (do_mode) state_nxt = S_EDIT_M;
      S_EDIT_M: if (do_mode) state_nxt = S_EDIT_S;
      S_EDIT_S: begin
        if (do_mode) begin
          state_nxt = S_IDLE;
          set_nxt   = 1'b1;
        end
      end
      S_RUN: begin
        // ring beats start and a coincident tick; abort beats everything
        if (do_clear) begin
          state_nxt = S_IDLE;
          rtm_nxt   = 1'b1;
        end else if (timer_ring) begin
          state_nxt = S_ALARM;
        end else if (do_start) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (do_clear) begin
          state_nxt = S_IDLE;
          rtm_nxt   = 1'b1;
        end else if (do_start) begin
          state_nxt = S_RUN;
        end
      end
      S_ALARM: begin
        if (any_btn || (tick && (secs == SEC_LAST))) begin
          state_nxt = S_IDLE;
          rtm_nxt   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Prescaler restarts from 0 on every entry into RUN or ALARM.
  always_comb begin
    cnt_nxt  = '0;
    secs_nxt = '0;
    if (((state == S_RUN) && (state_nxt == S_RUN)) ||
        ((state == S_ALARM) && (state_nxt == S_ALARM))) begin
      cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
    end
    if ((state == S_ALARM) && (state_nxt == S_ALARM)) begin
      secs_nxt = tick ? secs + SW'(1) : secs;
    end
  end

  always_comb begin
    case (state_nxt)
      S_EDIT_H: field_nxt = 2'd1;
      S_EDIT_M: field_nxt = 2'd2;
      S_EDIT_S: field_nxt = 2'd3;
      default:  field_nxt = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      secs        <= '0;
      loaded      <= 1'b0;
      hour_set    <= 8'h00;
      minute_set  <= 8'h00;
      second_set  <= 8'h00;
      set_timer   <= 1'b0;
      reset_timer <= 1'b0;
      pause       <= 1'b1;
      edit_field  <= 2'd0;
      alarm_out   <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      secs        <= secs_nxt;
      set_timer   <= set_nxt;
      reset_timer <= rtm_nxt;
      // pause is registered from next-state values so it is low exactly on tick cycles
      pause       <= ~((state_nxt == S_RUN) && (cnt_nxt == CNT_MAX));
      edit_field  <= field_nxt;
      alarm_out   <= (state_nxt == S_ALARM);
      running     <= (state_nxt == S_RUN);
      if (set_nxt) begin
        loaded <= 1'b1;
      end
      case (state)
        S_EDIT_H: begin
          if (do_clear)   hour_set <= 8'h00;
          else if (do_up) hour_set <= bcd_inc(hour_set, 8'h23);
        end
        S_EDIT_M: begin
          if (do_clear)   minute_set <= 8'h00;
          else if (do_up) minute_set <= bcd_inc(minute_set, 8'h59);
        end
        S_EDIT_S: begin
          if (do_clear)   second_set <= 8'h00;
          else if (do_up) second_set <= bcd_inc(second_set, 8'h59);
        end
        default: ;
      endcase
    end
  end

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n) !(set_timer && reset_timer));
  a_set_pulse:  assert property (@(posedge clk) disable iff (!rst_n) set_timer |=> !set_timer);
  a_rst_pulse:  assert property (@(posedge clk) disable iff (!rst_n) reset_timer |=> !reset_timer);

endmodule
